// File: rtl/spi_alu_frame.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_alu_frame: decodes a 20-bit SPI frame {op, A, B}, runs an 8-bit ALU   |
// | and shifts {status, result} back out. Macro SPI_ALU_MUL_EN enables MUL.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_alu_frame #(
  parameter int                    FRAME_BITS = 20,
  parameter logic [FRAME_BITS-1:0] RESP_RESET = 20'h00000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        shift_en,
  input  logic        transaction_done,
  input  logic        serial_out,
  output logic        serial_in,
  output logic [15:0] result,
  output logic [3:0]  status,
  output logic        result_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [4:0] c_COUNT_SAT   = 5'd31;
  localparam logic [4:0] c_FRAME_COUNT = 5'(FRAME_BITS);

  state_t                r_state, w_state_next;
  logic [FRAME_BITS-1:0] r_rx_shift, r_tx_shift, r_frame, w_rx_next;
  logic [4:0]            r_rx_count, w_count_next;
  logic                  r_short;
  logic [15:0]           r_result, w_alu, w_a, w_b;
  logic                  r_err, r_zero, r_carry, r_seq;
  logic                  w_carry, w_illegal, w_accept;

  // A shift_en coinciding with transaction_done must land in the latched frame.
  always_comb begin
    w_rx_next    = r_rx_shift;
    w_count_next = r_rx_count;
    if (shift_en) begin
      w_rx_next    = {r_rx_shift[FRAME_BITS-2:0], serial_out};
      w_count_next = (r_rx_count == c_COUNT_SAT) ? c_COUNT_SAT : r_rx_count + 5'd1;
    end
  end

  assign w_accept = transaction_done && (r_state == IDLE);

  always_comb begin
    w_a       = {8'h00, r_frame[15:8]};
    w_b       = {8'h00, r_frame[7:0]};
    w_alu     = 16'h0000;
    w_carry   = 1'b0;
    w_illegal = 1'b0;
    case (r_frame[19:16])
      4'd0: begin
        w_alu   = w_a + w_b;
        w_carry = w_alu[8];
      end
      4'd1: begin
        w_alu   = w_a - w_b;
        w_carry = (w_a < w_b);
      end
      4'd2: w_alu = w_a & w_b;
      4'd3: w_alu = w_a | w_b;
      4'd4: w_alu = w_a ^ w_b;
      4'd5: w_alu = w_a << r_frame[2:0];
      4'd6: w_alu = w_a >> r_frame[2:0];
`ifdef SPI_ALU_MUL_EN
      4'd7: w_alu = w_a * w_b;
`else
      4'd7: w_illegal = 1'b1;
`endif
      default: w_illegal = 1'b1;
    endcase
    if (r_short) begin
      w_alu     = 16'h0000;
      w_carry   = 1'b0;
      w_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Gating with reset_n keeps a reset during LOAD from showing a valid pulse.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (transaction_done) w_state_next = EXEC;
      end
      EXEC: begin
        w_state_next = LOAD;
        busy         = 1'b1;
      end
      LOAD: begin
        w_state_next = IDLE;
        busy         = 1'b1;
        result_valid = reset_n;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_shift <= '0;
      r_rx_count <= '0;
      r_frame    <= '0;
      r_short    <= 1'b0;
      r_tx_shift <= RESP_RESET;
      r_result   <= 16'h0000;
      r_err      <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_seq      <= 1'b0;
    end else begin
      r_rx_shift <= w_rx_next;
      r_rx_count <= w_accept ? 5'd0 : w_count_next;
      if (w_accept) begin
        r_frame <= w_rx_next;
        r_short <= (w_count_next != c_FRAME_COUNT);
      end
      if (r_state == LOAD) begin
        r_tx_shift <= {r_err, r_zero, r_carry, r_seq, r_result};
      end else if (shift_en) begin
        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
      end
      if (r_state == EXEC) begin
        r_result <= w_alu;
        r_err    <= w_illegal;
        r_zero   <= (w_alu == 16'h0000);
        r_carry  <= w_carry;
        r_seq    <= ~r_seq;
      end
    end
  end

  assign serial_in = r_tx_shift[FRAME_BITS-1];
  assign result    = r_result;
  assign status    = {r_err, r_zero, r_carry, r_seq};

endmodule
`default_nettype wire

// File: doc/spi_alu_frame.md
SPI_ALU_FRAME -- requirements
Module: spi_alu_frame

Interface
REQ-001 Parameter: FRAME_BITS, 20, frame length in bits; only 20 is supported.
REQ-002 Parameter: RESP_RESET, 20'h00000, tx shift register value after reset.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 shift_en  input  1  one-clk pulse per SPI bit from slave controller.
REQ-006 transaction_done  input  1  one-clk pulse at end of SPI frame.
REQ-007 serial_out  input  1  MOSI bit forwarded by slave; sampled when shift_en=1.
REQ-008 serial_in  output  1  MISO bit to slave; equals tx_shift[19].
REQ-009 result  output  16  last computed ALU result.
REQ-010 status  output  4  {err, zero, carry, seq}.
REQ-011 result_valid  output  1  one-clk pulse when result/status update.
REQ-012 busy  output  1  high while FSM is in EXEC or LOAD.

Function
REQ-013 Frame MSB first: [19:16] opcode, [15:8] operand A, [7:0] operand B.
REQ-014 On shift_en: rx_shift <= {rx_shift[18:0], serial_out}; tx_shift <= {tx_shift[18:0], 1'b0}; rx_count increments, saturating at 31.
REQ-015 FSM states: IDLE, EXEC, LOAD; IDLE->EXEC on transaction_done; EXEC->LOAD unconditionally; LOAD->IDLE unconditionally.
REQ-016 On transaction_done: frame latched from rx_shift; rx_count cleared. If shift_en is in the same cycle, its bit is included first.
REQ-017 EXEC: result computed on 16 bits from zero-extended A and B and registered.
REQ-018 Opcodes: 0 ADD, 1 SUB (mod 2^16; 3-5 = 16'hFFFE), 2 AND, 3 OR, 4 XOR, 5 SHL (A<<B[2:0]), 6 SHR (A>>B[2:0]), 7 MUL (A*B).
REQ-019 carry = result[8] for ADD; A<B for SUB; 0 otherwise.
REQ-020 zero = (result == 0); err = illegal opcode (8-15) or short frame.
REQ-021 seq toggles on every result_valid pulse.
REQ-022 Short frame: rx_count != 20 at transaction_done -> no compute; result = 0; err=1; zero=1.
REQ-023 LOAD: tx_shift <= {status, result}; result_valid pulses; a shift_en in that cycle shifts rx only and its tx shift is dropped.
REQ-024 Latency: transaction_done at cycle T -> result_valid at T+2; serial_in shows status[3] from T+3.
REQ-025 transaction_done while busy is ignored.

Reset
REQ-026 When reset_n=0 at a rising edge: FSM to IDLE; rx_shift=0; rx_count=0; tx_shift=RESP_RESET; result=0; status=0; result_valid=0; busy=0.
REQ-027 Reset mid-EXEC/LOAD aborts the operation; no result_valid is issued for that frame.

Configuration
REQ-028 Macro SPI_ALU_MUL_EN defined: opcode 7 computes the 8x8 product.
REQ-029 Macro SPI_ALU_MUL_EN undefined: opcode 7 is illegal (err=1, result=0) and no multiplier is synthesised.

Verification
REQ-030 ADD frame 20'h0FF01, 20 shift_en + transaction_done -> result=16'h0100; status=4'b0011 (first result, seq=1).
REQ-031 SUB frame 20'h10305 -> result=16'hFFFE, carry=1, zero=0, err=0; result_valid exactly 2 clks after transaction_done.
REQ-032 MUL frame 20'h7FFFF -> with SPI_ALU_MUL_EN result=16'hFE01; without it err=1 and result=0.
REQ-033 Short frame: 12 shift_en then transaction_done -> err=1, zero=1, result=0; next 20-bit frame computes normally.
REQ-034 Response shift-out: after ADD 20'h00203, next 20 shift_en -> serial_in sequence = status then 16'h0005, MSB first.
REQ-035 reset_n=0 in the cycle after transaction_done -> no result_valid; all outputs return to reset values; serial_in=RESP_RESET[19].
